// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - shared types and constants for the RV32M sequencer
package muldiv_seq_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 5;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/response bundle between issue logic and the sequencer
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic            START;
  logic [2:0]      OP;
  logic [XLEN-1:0] SRC1;
  logic [XLEN-1:0] SRC2;
  logic [4:0]      RD_IN;
  logic            READY;
  logic            RESULT_VALID;
  logic [XLEN-1:0] RESULT;
  logic [4:0]      RD_OUT;

  modport master (output START, OP, SRC1, SRC2, RD_IN,
                  input  READY, RESULT_VALID, RESULT, RD_OUT);
  modport slave  (input  START, OP, SRC1, SRC2, RD_IN,
                  output READY, RESULT_VALID, RESULT, RD_OUT);
endinterface

// File: rtl/muldiv_seq_div_step.sv
// rtl/muldiv_seq_div_step.sv - one combinational restoring-division step
module div_step
  import muldiv_seq_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quot,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quot
);
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  // The dividend shifts out of i_quot MSB-first while quotient bits shift in.
  assign w_shift = {i_rem, i_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_ge    = ~w_diff[XLEN];
  assign o_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quot  = {i_quot[XLEN-2:0], w_ge};
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - RV32M multiply/divide sequencer (2-cycle mul, 32-step divide)
// Optional single-entry divide result cache: MULDIV_RESULT_CACHE_EN.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  muldiv_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

  muldiv_state_t   r_state, w_state_nxt;
  logic            w_ready, w_valid, w_accept;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_src1, r_src2, r_rem, r_quot, r_divisor, r_result;
  logic [4:0]      r_rd_pend, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic            r_neg_q, r_neg_r;

  logic            w_signed, w_zero, w_ovf, w_fast;
  logic [XLEN-1:0] w_abs1, w_abs2, w_fast_res;
  logic [XLEN-1:0] w_rem_nxt, w_quot_nxt, w_rem_fin, w_quot_fin, w_mul_res;
  logic [2*XLEN-1:0] w_a, w_b, w_prod;
  logic            w_a_sgn, w_b_sgn;

`ifdef MULDIV_RESULT_CACHE_EN
  logic            r_c_valid, r_c_signed, w_hit;
  logic [XLEN-1:0] r_c_src1, r_c_src2, r_c_quot, r_c_rem;
  assign w_hit = r_c_valid && (r_c_signed == w_signed) &&
                 (r_c_src1 == bus.SRC1) && (r_c_src2 == bus.SRC2);
`endif

  assign w_signed = ~bus.OP[0];
  assign w_zero   = (bus.SRC2 == '0);
  assign w_ovf    = w_signed && (bus.SRC1 == INT_MIN) && (bus.SRC2 == '1);
  assign w_abs1   = (w_signed && bus.SRC1[XLEN-1]) ? -bus.SRC1 : bus.SRC1;
  assign w_abs2   = (w_signed && bus.SRC2[XLEN-1]) ? -bus.SRC2 : bus.SRC2;
  assign w_accept = bus.START && w_ready;

  always_comb begin
    w_fast     = w_zero || w_ovf;
    w_fast_res = bus.OP[1] ? bus.SRC1 : DIV_ZERO_Q;
    if (w_zero) begin
      w_fast_res = bus.OP[1] ? bus.SRC1 : DIV_ZERO_Q;
    end else if (w_ovf) begin
      w_fast_res = bus.OP[1] ? '0 : INT_MIN;
    end
`ifdef MULDIV_RESULT_CACHE_EN
    else if (w_hit) begin
      w_fast     = 1'b1;
      w_fast_res = bus.OP[1] ? r_c_rem : r_c_quot;
    end
`endif
  end

  // Sign-extend into 64 bits so a plain 64-bit product covers all three signedness mixes.
  assign w_a_sgn   = (r_op != OP_MULHU);
  assign w_b_sgn   = (r_op == OP_MUL) || (r_op == OP_MULH);
  assign w_a       = {{XLEN{w_a_sgn & r_src1[XLEN-1]}}, r_src1};
  assign w_b       = {{XLEN{w_b_sgn & r_src2[XLEN-1]}}, r_src2};
  assign w_prod    = w_a * w_b;
  assign w_mul_res = (r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nxt),
    .o_quot    (w_quot_nxt)
  );

  assign w_quot_fin = r_neg_q ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fin  = r_neg_r ? -w_rem_nxt  : w_rem_nxt;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        w_ready     = 1'b1;
        w_valid     = (r_state == DONE);
        w_state_nxt = IDLE;
        if (bus.START) begin
          if (!bus.OP[2])  w_state_nxt = MUL;
          else if (w_fast) w_state_nxt = DONE;
          else             w_state_nxt = DIV;
        end
      end
      MUL:     w_state_nxt = DONE;
      DIV:     if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op <= '0; r_src1 <= '0; r_src2 <= '0; r_rd_pend <= '0;
      r_rem <= '0; r_quot <= '0; r_divisor <= '0; r_cnt <= '0;
      r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_result <= '0; r_rd <= '0;
`ifdef MULDIV_RESULT_CACHE_EN
      r_c_valid <= 1'b0; r_c_signed <= 1'b0; r_c_src1 <= '0;
      r_c_src2 <= '0; r_c_quot <= '0; r_c_rem <= '0;
`endif
    end else if (w_accept) begin
      r_op      <= bus.OP;
      r_src1    <= bus.SRC1;
      r_src2    <= bus.SRC2;
      r_rd_pend <= bus.RD_IN;
      r_rem     <= '0;
      r_quot    <= w_abs1;
      r_divisor <= w_abs2;
      r_cnt     <= '0;
      r_neg_q   <= w_signed && (bus.SRC1[XLEN-1] ^ bus.SRC2[XLEN-1]);
      r_neg_r   <= w_signed && bus.SRC1[XLEN-1];
      if (bus.OP[2] && w_fast) begin
        r_result <= w_fast_res;
        r_rd     <= bus.RD_IN;
      end
    end else if (r_state == MUL) begin
      r_result <= w_mul_res;
      r_rd     <= r_rd_pend;
    end else if (r_state == DIV) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_result <= r_op[1] ? w_rem_fin : w_quot_fin;
        r_rd     <= r_rd_pend;
`ifdef MULDIV_RESULT_CACHE_EN
        r_c_valid  <= 1'b1;
        r_c_signed <= ~r_op[0];
        r_c_src1   <= r_src1;
        r_c_src2   <= r_src2;
        r_c_quot   <= w_quot_fin;
        r_c_rem    <= w_rem_fin;
`endif
      end
    end
  end

  assign bus.READY        = w_ready;
  assign bus.RESULT_VALID = w_valid;
  assign bus.RESULT       = r_result;
  assign bus.RD_OUT       = r_rd;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Issue one op and count falling edges after the accepting edge until RESULT_VALID.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] res,
                        output logic [4:0] rdo);
    @(negedge CLK);
    bus.START = 1'b1; bus.OP = op; bus.SRC1 = a; bus.SRC2 = b; bus.RD_IN = rd;
    @(posedge CLK);
    lat = -1; res = 'x; rdo = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      if (k == 1) bus.START = 1'b0;
      if (bus.RESULT_VALID === 1'b1) begin
        lat = k; res = bus.RESULT; rdo = bus.RD_OUT;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.START = 1'b0; bus.OP = '0; bus.SRC1 = '0; bus.SRC2 = '0; bus.RD_IN = '0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (bus.READY !== 1'b1 || bus.RESULT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags ready=%b valid=%b required ready=1 valid=0", bus.READY, bus.RESULT_VALID);
    end
    checks++;
    if (bus.RESULT !== 32'h0 || bus.RD_OUT !== 5'h0) begin
      failures++;
      $display("FAIL reset_outputs result=%h rd=%0d required 0/0", bus.RESULT, bus.RD_OUT);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
    logic [31:0] as  [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
    int lat; logic [31:0] res; logic [4:0] rdo;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 1), lat, res, rdo);
      checks++;
      if (lat != 2 || res !== exp[i] || rdo !== 5'(i + 1)) begin
        failures++;
        $display("FAIL mul_%0d lat=%0d res=%h rd=%0d required lat=2 res=%h rd=%0d",
                 i, lat, res, rdo, exp[i], i + 1);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b100, 3'b110};
    logic [31:0] as  [6] = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'h80000000, 32'd7, 32'd7};
    logic [31:0] bs  [6] = '{32'd3, 32'd3, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] exp [6] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd2, 32'd0, 32'hFFFFFFFD, 32'd1};
    int lat; logic [31:0] res; logic [4:0] rdo;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 10), lat, res, rdo);
      checks++;
      if (lat != 33 || res !== exp[i] || rdo !== 5'(i + 10)) begin
        failures++;
        $display("FAIL div_%0d lat=%0d res=%h rd=%0d required lat=33 res=%h rd=%0d",
                 i, lat, res, rdo, exp[i], i + 10);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] as  [4] = '{32'd123, 32'd123, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd123, 32'h80000000, 32'd0};
    int lat; logic [31:0] res; logic [4:0] rdo;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 5'(i + 20), lat, res, rdo);
      checks++;
      if (lat != 1 || res !== exp[i] || rdo !== 5'(i + 20)) begin
        failures++;
        $display("FAIL special_%0d lat=%0d res=%h rd=%0d required lat=1 res=%h rd=%0d",
                 i, lat, res, rdo, exp[i], i + 20);
      end
    end
  endtask

  task automatic test_busy();
    int lat = -1; int nvalid = 0; int busy_err = 0;
    logic [31:0] res = '0; logic [4:0] rdo = '0;
    @(negedge CLK);
    bus.START = 1'b1; bus.OP = 3'b100; bus.SRC1 = 32'hFFFFFFEC; bus.SRC2 = 32'd3; bus.RD_IN = 5'd5;
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) bus.START = 1'b0;
      if (k == 5) begin
        bus.START = 1'b1; bus.OP = 3'b000; bus.SRC1 = 32'd1; bus.SRC2 = 32'd1; bus.RD_IN = 5'd9;
      end
      if (k == 6) bus.START = 1'b0;
      if (k < 33 && bus.READY !== 1'b0) busy_err++;
      if (bus.RESULT_VALID === 1'b1) begin
        nvalid++;
        if (lat < 0) begin lat = k; res = bus.RESULT; rdo = bus.RD_OUT; end
      end
    end
    checks++;
    if (busy_err != 0 || nvalid != 1) begin
      failures++;
      $display("FAIL busy_ignore ready_high_cycles=%0d valid_pulses=%0d required 0 and 1", busy_err, nvalid);
    end
    checks++;
    if (lat != 33 || res !== 32'hFFFFFFFA || rdo !== 5'd5) begin
      failures++;
      $display("FAIL busy_result lat=%0d res=%h rd=%0d required lat=33 res=fffffffa rd=5", lat, res, rdo);
    end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1; int lat2 = -1;
    logic [31:0] res1 = '0; logic [31:0] res2 = '0; logic [4:0] rd2 = '0;
    @(negedge CLK);
    bus.START = 1'b1; bus.OP = 3'b100; bus.SRC1 = 32'd100; bus.SRC2 = 32'd9; bus.RD_IN = 5'd3;
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (k == 1) bus.START = 1'b0;
      if (bus.RESULT_VALID === 1'b1) begin
        lat1 = k; res1 = bus.RESULT;
        bus.START = 1'b1; bus.OP = 3'b000; bus.SRC1 = 32'd6; bus.SRC2 = 32'd7; bus.RD_IN = 5'd4;
        break;
      end
    end
    @(posedge CLK);
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      if (k == 1) bus.START = 1'b0;
      if (bus.RESULT_VALID === 1'b1) begin lat2 = k; res2 = bus.RESULT; rd2 = bus.RD_OUT; break; end
    end
    bus.START = 1'b0;
    checks++;
    if (lat1 != 33 || res1 !== 32'd11) begin
      failures++;
      $display("FAIL b2b_div lat=%0d res=%h required lat=33 res=0000000b", lat1, res1);
    end
    checks++;
    if (lat2 != 2 || res2 !== 32'd42 || rd2 !== 5'd4) begin
      failures++;
      $display("FAIL b2b_mul lat=%0d res=%h rd=%0d required lat=2 res=0000002a rd=4", lat2, res2, rd2);
    end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0; logic ready_after = 1'b0;
    @(negedge CLK);
    bus.START = 1'b1; bus.OP = 3'b100; bus.SRC1 = 32'd50; bus.SRC2 = 32'd5; bus.RD_IN = 5'd7;
    @(posedge CLK);
    for (int k = 1; k <= 50; k++) begin
      @(negedge CLK);
      if (k == 1) bus.START = 1'b0;
      if (k == 10) RST = 1'b1;
      if (k == 11) begin RST = 1'b0; ready_after = bus.READY; end
      if (bus.RESULT_VALID === 1'b1) nvalid++;
    end
    checks++;
    if (ready_after !== 1'b1 || nvalid != 0) begin
      failures++;
      $display("FAIL reset_mid ready=%b valid_pulses=%0d required ready=1 pulses=0", ready_after, nvalid);
    end
    checks++;
    if (bus.RESULT !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_result res=%h required 00000000", bus.RESULT);
    end
  endtask

  task automatic test_cache();
    int lat; logic [31:0] res; logic [4:0] rdo;
    int exp_hit_lat;
`ifdef MULDIV_RESULT_CACHE_EN
    exp_hit_lat = 1;
`else
    exp_hit_lat = 33;
`endif
    run_op(3'b100, 32'd100, 32'd7, 5'd1, lat, res, rdo);
    checks++;
    if (lat != 33 || res !== 32'd14) begin
      failures++;
      $display("FAIL cache_fill lat=%0d res=%h required lat=33 res=0000000e", lat, res);
    end
    run_op(3'b110, 32'd100, 32'd7, 5'd2, lat, res, rdo);
    checks++;
    if (lat != exp_hit_lat || res !== 32'd2 || rdo !== 5'd2) begin
      failures++;
      $display("FAIL cache_rem lat=%0d res=%h rd=%0d required lat=%0d res=00000002 rd=2",
               lat, res, rdo, exp_hit_lat);
    end
    run_op(3'b101, 32'd100, 32'd7, 5'd3, lat, res, rdo);
    checks++;
    if (lat != 33 || res !== 32'd14) begin
      failures++;
      $display("FAIL cache_sign_miss lat=%0d res=%h required lat=33 res=0000000e", lat, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    test_cache();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
